// File: rtl/mem_copy_dma_pkg.sv
// mem_copy_dma_pkg: shared state encoding, default widths and memory strobe values for the copy engine.
package mem_copy_dma_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam logic MEM_READ = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: request, CPU-side and DataMem-side signals of the copy engine; checksum present with MEM_COPY_DMA_CHECKSUM_EN.
interface mem_copy_dma_if import mem_copy_dma_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] srcAddr;
    logic [ADDR_W-1:0] dstAddr;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cpuAddr;
    logic [DATA_W-1:0] cpuDataIn;
    logic              cpuMemOp;
    logic [DATA_W-1:0] memDataOut;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataIn;
    logic              memOp;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] count;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
    modport master (
        input  start, srcAddr, dstAddr, len, cpuAddr, cpuDataIn, cpuMemOp, memDataOut,
        output memAddr, memDataIn, memOp, busy, done, count, checksum
    );
    modport slave (
        output start, srcAddr, dstAddr, len, cpuAddr, cpuDataIn, cpuMemOp, memDataOut,
        input  memAddr, memDataIn, memOp, busy, done, count, checksum
    );
`else
    modport master (
        input  start, srcAddr, dstAddr, len, cpuAddr, cpuDataIn, cpuMemOp, memDataOut,
        output memAddr, memDataIn, memOp, busy, done, count
    );
    modport slave (
        output start, srcAddr, dstAddr, len, cpuAddr, cpuDataIn, cpuMemOp, memDataOut,
        input  memAddr, memDataIn, memOp, busy, done, count
    );
`endif
endinterface

// File: rtl/mem_copy_dma_mem_port_mux.sv
// mem_port_mux: hands the DataMem port to the copy engine while busy, otherwise to the CPU.
module mem_port_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              busy_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_op_i,
    input  logic [ADDR_W-1:0] eng_addr_i,
    input  logic [DATA_W-1:0] eng_data_i,
    input  logic              eng_op_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_op_o
);
    always_comb begin
        mem_addr_o = busy_i ? eng_addr_i : cpu_addr_i;
        mem_data_o = busy_i ? eng_data_i : cpu_data_i;
        mem_op_o   = busy_i ? eng_op_i : cpu_op_i;
    end
endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: byte-at-a-time memory copy engine in front of DataMem; MEM_COPY_DMA_CHECKSUM_EN adds a running byte checksum.
module mem_copy_dma import mem_copy_dma_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    mem_copy_dma_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] count_inc;
    logic              accept;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;
    logic              eng_op;
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end
    assign count_inc = count_q + ADDR_W'(1);
    assign accept    = (state_q == IDLE) && bus.start;
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                src_d   = bus.srcAddr;
                dst_d   = bus.dstAddr;
                len_d   = bus.len;
                count_d = '0;
                state_d = (bus.len != '0) ? READ : DONE;
            end
            READ: begin
                buf_d   = bus.memDataOut;
                state_d = WRITE;
            end
            WRITE: begin
                count_d = count_inc;
                state_d = (count_inc == len_q) ? DONE : READ;
            end
            default: state_d = IDLE;
        endcase
    end
    // Source and destination share the running count as their offset, so overlap propagates forward.
    always_comb begin
        eng_addr = ((state_q == WRITE) ? dst_q : src_q) + count_q;
        eng_data = (state_q == WRITE) ? buf_q : '0;
        eng_op   = (state_q == WRITE) ? MEM_WRITE : MEM_READ;
    end
    assign bus.busy  = state_q != IDLE;
    assign bus.done  = state_q == DONE;
    assign bus.count = count_q;
    mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .busy_i     (bus.busy),
        .cpu_addr_i (bus.cpuAddr),
        .cpu_data_i (bus.cpuDataIn),
        .cpu_op_i   (bus.cpuMemOp),
        .eng_addr_i (eng_addr),
        .eng_data_i (eng_data),
        .eng_op_i   (eng_op),
        .mem_addr_o (bus.memAddr),
        .mem_data_o (bus.memDataIn),
        .mem_op_o   (bus.memOp)
    );
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;
    always_comb chk_d = accept ? '0 : (state_q == WRITE) ? chk_q + buf_q : chk_q;
    always_ff @(posedge CLK) begin
        if (!RST_N) chk_q <= '0;
        else chk_q <= chk_d;
    end
    assign bus.checksum = chk_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: random and directed copies checked against an array model of DataMem; checksum checked with MEM_COPY_DMA_CHECKSUM_EN.
module tb_mem_copy_dma;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    mem_copy_dma_if bus();
    mem_copy_dma dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
    always #5 CLK = ~CLK;
    always @(posedge CLK) if (bus.memOp === 1'b1) mem[bus.memAddr] <= bus.memDataIn;
    assign bus.memDataOut = mem[bus.memAddr];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, " mem"}, bad, 0);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.cpuAddr = a;
        bus.cpuDataIn = d;
        bus.cpuMemOp = 1'b1;
        tick;
        bus.cpuMemOp = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int l, output logic [7:0] sum);
        logic [7:0] v;
        sum = 8'h00;
        for (int i = 0; i < l; i++) begin
            v = ref_mem[8'(int'(s) + i)];
            ref_mem[8'(int'(d) + i)] = v;
            sum = sum + v;
        end
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input bit inject, input string tag);
        logic [7:0] sum;
        int lat = 0;
        bit saw_op = 0;
        bus.srcAddr = s;
        bus.dstAddr = d;
        bus.len = l;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check({tag, " busy"}, bus.busy, 1);
        while (bus.done !== 1'b1 && lat < 600) begin
            if (inject && lat == 2) begin
                bus.start = 1'b1;
                bus.cpuAddr = 8'h50;
                bus.cpuDataIn = 8'hEE;
                bus.cpuMemOp = 1'b1;
                #1;
                check({tag, " cpu blocked"}, bus.memOp, 0);
            end
            if (bus.memOp === 1'b1) saw_op = 1;
            tick;
            lat++;
            bus.start = 1'b0;
            bus.cpuMemOp = 1'b0;
        end
        ref_copy(s, d, int'(l), sum);
        if (l == 0) begin
            check({tag, " lat"}, lat <= 1, 1);
            check({tag, " no write"}, saw_op, 0);
        end else check({tag, " lat"}, lat, 2 * int'(l));
        check({tag, " count"}, bus.count, l);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check({tag, " checksum"}, bus.checksum, sum);
`endif
        tick;
        check({tag, " done pulse"}, {bus.done, bus.busy}, 2'b00);
        check({tag, " count hold"}, bus.count, l);
        tick;
        check({tag, " idle"}, bus.busy, 0);
        mem_check(tag);
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] prev50;
        bit saw_done;
        bus.start = 0;
        bus.srcAddr = 0;
        bus.dstAddr = 0;
        bus.len = 0;
        bus.cpuAddr = 0;
        bus.cpuDataIn = 0;
        bus.cpuMemOp = 0;
        tick;
        tick;
        check("reset", {bus.busy, bus.done, bus.memOp}, 3'b000);
        check("reset count", bus.count, 0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check("reset checksum", bus.checksum, 0);
`endif
        RST_N = 1'b1;
        for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'($urandom));
        mem_check("preload");
        cpu_write(8'h10, 8'hA1);
        cpu_write(8'h11, 8'hB2);
        cpu_write(8'h12, 8'hC3);
        cpu_write(8'h13, 8'hD4);
        run_copy(8'h10, 8'h40, 8'd4, 0, "basic");
        check("basic last byte", mem[8'h43], 8'hD4);
        run_copy(8'h05, 8'h06, 8'd0, 0, "zero");
        cpu_write(8'hFE, 8'h11);
        cpu_write(8'hFF, 8'h22);
        cpu_write(8'h00, 8'h33);
        run_copy(8'hFE, 8'h80, 8'd3, 0, "wrap");
        check("wrap byte2", mem[8'h82], 8'h33);
        cpu_write(8'h20, 8'h01);
        cpu_write(8'h21, 8'h02);
        cpu_write(8'h22, 8'h03);
        cpu_write(8'h23, 8'h04);
        prev50 = ref_mem[8'h50];
        run_copy(8'h20, 8'h21, 8'd3, 1, "overlap");
        check("overlap byte3", mem[8'h23], 8'h01);
        check("overlap cpu drop", mem[8'h50], prev50);
        cpu_write(8'h30, 8'hFF);
        cpu_write(8'h31, 8'h02);
        cpu_write(8'h32, 8'h10);
        run_copy(8'h30, 8'hA0, 8'd3, 0, "chk");
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check("chk const", bus.checksum, 8'h11);
`endif
        bus.srcAddr = 8'h60;
        bus.dstAddr = 8'h90;
        bus.len = 8'd8;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        saw_done = 0;
        repeat (4) begin
            tick;
            if (bus.done === 1'b1) saw_done = 1;
        end
        RST_N = 1'b0;
        tick;
        check("rst busy", {bus.busy, bus.done, bus.memOp}, 3'b000);
        check("rst count", bus.count, 0);
        check("rst no done", saw_done, 0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        check("rst checksum", bus.checksum, 0);
`endif
        RST_N = 1'b1;
        ref_copy(8'h60, 8'h90, 2, sum);
        mem_check("rst partial");
        cpu_write(8'h92, 8'h5A);
        mem_check("rst passthrough");
        repeat (6) run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(1, 24)), 0, "rand");
        run_copy(8'($urandom), 8'($urandom), 8'd255, 0, "max");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Initiator-side engine for the single-port byte DataMem: memory address, write data, write strobe (memOp, 1 = write) and combinational read data.
- On a start pulse it copies len bytes from srcAddr to dstAddr, one read/write pair at a time.
- Sits between the CPU datapath's memory port and DataMem. It muxes the CPU's address/data/memOp through to DataMem when idle and takes the port while busy.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  synchronous active-low reset, sampled on posedge CLK.
- start  input  1  request pulse; sampled only in IDLE.
- srcAddr  input  ADDR_W  first source address; latched on accepted start.
- dstAddr  input  ADDR_W  first destination address; latched on accepted start.
- len  input  ADDR_W  byte count; 0 means no transfer.
- cpuAddr  input  ADDR_W  CPU memory address, passed through when idle.
- cpuDataIn  input  DATA_W  CPU write data, passed through when idle.
- cpuMemOp  input  1  CPU write strobe, passed through when idle.
- memDataOut  input  DATA_W  DataMem combinational read data.
- memAddr  output  ADDR_W  to DataMem address.
- memDataIn  output  DATA_W  to DataMem write data.
- memOp  output  1  to DataMem write strobe.
- busy  output  1  high in READ, WRITE and DONE; the CPU must stall.
- done  output  1  one-cycle completion pulse.
- count  output  ADDR_W  bytes written so far in the current transfer.

Behaviour:
- Clock and reset:
  - One clock (CLK).
  - Reset is synchronous and active-low (RST_N).
  - Reset values: state=IDLE, count=0, buf=0, latched src/dst/len=0, busy=0, done=0.
  - memOp is combinational and therefore 0 immediately on reset, because the mux selects the CPU path in IDLE.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem* outputs = cpu* inputs.
  - On start=1 with len!=0: latch srcAddr, dstAddr and len; count<=0; go to READ.
  - On start=1 with len==0: go to DONE (no memory access).
- READ:
  - memAddr = src+count (mod 2^ADDR_W), memOp=0, memDataIn=0.
  - At posedge: buf<=memDataOut; go to WRITE.
- WRITE:
  - memAddr = dst+count (mod 2^ADDR_W), memDataIn=buf, memOp=1.
  - At posedge: count<=count+1.
  - If count+1==len, go to DONE; else go to READ.
- DONE: done=1, memOp=0; next cycle go to IDLE. count holds its final value until the next accepted start.
- Latency: start accepted at edge N; done is high in the cycle after edge N+2*len. len==0 gives done in the cycle after edge N+1.
- Start while busy (READ, WRITE or DONE) is ignored; it is not queued.
- CPU inputs are ignored while busy. The CPU must honour busy; a CPU write attempted while busy is dropped.
- Overlapping regions are copied in ascending byte order with no hazard correction. With dst=src+1 the first byte propagates through the region, and this is the specified result.
- Address arithmetic wraps, e.g. src=0xFF, len=2 reads 0xFF then 0x00.
- len=255 is the maximum transfer.
- Reset mid-transfer: return to IDLE. Bytes already written remain; no done pulse.

Optional Feature:
- Macro: MEM_COPY_DMA_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_W-1:0], cleared on accepted start.
  - Updated in WRITE: checksum <= checksum + buf (modulo 2^DATA_W).
  - Valid and stable from the done pulse until the next accepted start. Reset value 0.
- When undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package mem_copy_dma_pkg: state enum (IDLE, READ, WRITE, DONE), ADDR_W/DATA_W defaults, MEM_READ=1'b0 / MEM_WRITE=1'b1 constants.
- One natural sub-module, mem_port_mux: combinational 2:1 select of {addr, dataIn, memOp} between CPU and engine, controlled by busy.
- The FSM and counters stay in the top module.

Test Plan:
- Basic copy: mem[0x10..0x13]={A1,B2,C3,D4}, start src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]={A1,B2,C3,D4}; done pulses 9 cycles after the start edge; count=4.
- Zero length: len=0 start -> done 2 cycles after the start edge; memOp never 1; memory unchanged.
- Wrap: mem[0xFE]=11, mem[0xFF]=22, mem[0x00]=33; src=0xFE dst=0x80 len=3 -> mem[0x80..0x82]={11,22,33}.
- Overlap and busy: mem[0x20..0x23]={01,02,03,04}; start src=0x20 dst=0x21 len=3, with a second start and cpuMemOp=1 to 0x50 asserted mid-transfer -> mem[0x21..0x23]={01,01,01}; second start ignored; mem[0x50] unchanged.
- Reset mid-op: len=8, RST_N=0 after 5 cycles -> next cycle IDLE, busy=0, count=0; only bytes 0..1 written; no done; CPU passthrough write works afterwards.
- Checksum (MEM_COPY_DMA_CHECKSUM_EN): copy {FF,02,10} -> checksum=0x11 at done.
